log2_iter: RTL and testbench

Parametrised iterative fixed-point base-2 logarithm unit. It is the successor to the fixed 16-bit log2 core. For an unsigned DATA_W-bit input it returns the integer part (leading-one position) and a FRAC_W-bit fractional part by repeated mantissa squaring. It adds a start/valid/ready handshake, output backpressure and a zero-input error flag, and sits as a compute leaf behind a register/stream front end.

---
 rtl/log2_pkg.sv | 16 +
 rtl/log2_lod.sv | 22 ++
 rtl/log2_iter.sv | 120 ++++++++++++
 tb/tb_log2_iter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/log2_pkg.sv
// Shared types and width helpers for the iterative log2 unit.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to index n values, never less than one.
    function automatic int log2_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/log2_lod.sv
// Combinational leading-one detector: position of the highest set bit plus a zero flag.
module log2_lod
    import log2_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int INT_W  = log2_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    output logic [INT_W-1:0]  pos,
    output logic              zero
);

    // Scan upward so the last set bit seen is the most significant one.
    always_comb begin
        pos  = {INT_W{1'b0}};
        zero = ~|data;
        for (int i = 0; i < DATA_W; i++) begin
            pos = data[i] ? INT_W'(i) : pos;
        end
    end

endmodule

// File: rtl/log2_iter.sv
// Iterative fixed-point log2: leading-one normalisation, then one fraction bit per
// cycle by squaring the mantissa. Start/ready in, valid/ready out with backpressure.
module log2_iter
    import log2_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int FRAC_W = 16,
    localparam int INT_W  = log2_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INT_W-1:0]  y_int_o,
    output logic [FRAC_W-1:0] y_frac_o,
    output logic              err_o
);

    localparam int CNT_W = log2_w(FRAC_W + 1);
    localparam int PW    = 2 * DATA_W;

    state_t            state_r;
    logic [DATA_W-1:0] x_r;
    logic [DATA_W-1:0] m_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [INT_W-1:0]  y_int_r;
    logic [FRAC_W-1:0] y_frac_r;
    logic              err_r;
    logic              ready_r;
    logic              valid_r;

    logic [INT_W-1:0]  lod_pos_s;
    logic              lod_zero_s;
    logic [INT_W-1:0]  shift_s;
    logic [DATA_W:0]   sq_top_s;

    log2_lod #(.DATA_W(DATA_W)) u_lod (
        .data (x_r),
        .pos  (lod_pos_s),
        .zero (lod_zero_s)
    );

    assign shift_s = INT_W'(DATA_W - 1) - lod_pos_s;

    // m*m is Q2.(2*DATA_W-2); keeping bits [2*DATA_W-1:DATA_W-1] is enough for either
    // renormalisation choice, the rest is truncated.
    assign sq_top_s = (DATA_W + 1)'((PW'(m_r) * PW'(m_r)) >> (DATA_W - 1));

    assign ready_o  = ready_r;
    assign valid_o  = valid_r;
    assign y_int_o  = y_int_r;
    assign y_frac_o = y_frac_r;
    assign err_o    = err_r;

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            x_r      <= {DATA_W{1'b0}};
            m_r      <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            y_int_r  <= {INT_W{1'b0}};
            y_frac_r <= {FRAC_W{1'b0}};
            err_r    <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        x_r     <= data_i;
                        ready_r <= 1'b0;
                        state_r <= NORM;
                    end
                end
                NORM: begin
                    cnt_r    <= {CNT_W{1'b0}};
                    y_frac_r <= {FRAC_W{1'b0}};
                    if (lod_zero_s) begin
                        err_r   <= 1'b1;
                        y_int_r <= {INT_W{1'b0}};
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        err_r   <= 1'b0;
                        y_int_r <= lod_pos_s;
                        m_r     <= x_r << shift_s;
                        state_r <= ITER;
                    end
                end
                ITER: begin
                    // A square >= 2 yields a one bit and is halved back into [1,2).
                    y_frac_r <= FRAC_W'({y_frac_r, sq_top_s[DATA_W]});
                    m_r      <= sq_top_s[DATA_W] ? sq_top_s[DATA_W:1] : sq_top_s[DATA_W-1:0];
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(FRAC_W - 1)) begin
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_iter.sv
// Self-checking bench for log2_iter: directed table, handshake corner cases and
// randomized operands checked against a real-valued logarithm model.
module tb_log2_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        start_a, rdy_a, vld_a, cons_a, err_a;
    logic [15:0] data_a, yf_a;
    logic [3:0]  yi_a;
    logic        start_b, rdy_b, vld_b, cons_b, err_b;
    logic [7:0]  data_b, yf_b;
    logic [2:0]  yi_b;

    log2_iter #(.DATA_W(16), .FRAC_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_a), .data_i(data_a),
        .ready_o(rdy_a), .valid_o(vld_a), .ready_i(cons_a),
        .y_int_o(yi_a), .y_frac_o(yf_a), .err_o(err_a)
    );

    log2_iter #(.DATA_W(8), .FRAC_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_b), .data_i(data_b),
        .ready_o(rdy_b), .valid_o(vld_b), .ready_i(cons_b),
        .y_int_o(yi_b), .y_frac_o(yf_b), .err_o(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        int          exp_int;
        int          exp_frac;
        int          tol;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check_rng(name, act, exp, exp);
    endtask

    function automatic int ref_int(input int x);
        int k = 0;
        while ((longint'(1) << (k + 1)) <= longint'(x)) k++;
        return k;
    endfunction

    function automatic int ref_frac(input int x, input int fw);
        real r;
        r = $ln(real'(x)) / $ln(2.0) - real'(ref_int(x));
        return int'($floor(r * real'(longint'(1) << fw)));
    endfunction

    // Issue one operation on DUT a (sel=0) or b (sel=1) and wait for its result.
    task automatic op(input bit sel, input logic [15:0] d, output int lat,
                      output int yi, output int yf, output int er);
        @(negedge clk);
        if (sel) begin start_b = 1'b1; data_b = d[7:0]; end
        else     begin start_a = 1'b1; data_a = d;      end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (!(sel ? vld_b : vld_a) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        yi = sel ? int'(yi_b) : int'(yi_a);
        yf = sel ? int'(yf_b) : int'(yf_a);
        er = sel ? int'(err_b) : int'(err_a);
    endtask

    initial begin
        int lat, yi, yf, er, yi0, yf0, seen, x, rf;

        vecs[0] = '{16'h0001, 0,  16'h0000, 0, 1'b0, 18};
        vecs[1] = '{16'h8000, 15, 16'h0000, 0, 1'b0, 18};
        vecs[2] = '{16'hFFFF, 15, 16'hFFFE, 2, 1'b0, 18};
        vecs[3] = '{16'h0003, 1,  16'h95C0, 2, 1'b0, 18};
        vecs[4] = '{16'h000A, 3,  16'h526A, 2, 1'b0, 18};
        vecs[5] = '{16'h0000, 0,  16'h0000, 0, 1'b1, 2};

        rst_i = 1'b1;
        start_a = 1'b0; data_a = 16'h0000; cons_a = 1'b1;
        start_b = 1'b0; data_b = 8'h00;    cons_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", int'(rdy_a), 1);
        check_eq("rst_valid", int'(vld_a), 0);
        check_eq("rst_yint",  int'(yi_a), 0);
        check_eq("rst_yfrac", int'(yf_a), 0);
        check_eq("rst_err",   int'(err_a), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            op(1'b0, vecs[i].data, lat, yi, yf, er);
            check_eq($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check_eq($sformatf("vec%0d_yint", i), yi, vecs[i].exp_int);
            check_rng($sformatf("vec%0d_yfrac", i), yf,
                      vecs[i].exp_frac - vecs[i].tol, vecs[i].exp_frac + vecs[i].tol);
            check_eq($sformatf("vec%0d_err", i), er, int'(vecs[i].exp_err));
        end

        // Backpressure with stray start pulses during ITER and DONE.
        @(negedge clk);
        cons_a = 1'b0; start_a = 1'b1; data_a = 16'd10;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 30 && !vld_a; c++) begin
            start_a = (c % 3 == 0);
            data_a  = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
        end
        start_a = 1'b0;
        check_eq("bp_valid", int'(vld_a), 1);
        check_eq("bp_yint", int'(yi_a), 3);
        check_rng("bp_yfrac", int'(yf_a), 16'h526A - 2, 16'h526A + 2);
        yi0 = int'(yi_a);
        yf0 = int'(yf_a);
        for (int c = 0; c < 10; c++) begin
            start_a = (c % 2 == 0);
            data_a  = 16'h1234;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_hold_valid", int'(vld_a), 1);
            check_eq("bp_hold_ready", int'(rdy_a), 0);
            check_eq("bp_hold_yint", int'(yi_a), yi0);
            check_eq("bp_hold_yfrac", int'(yf_a), yf0);
        end
        start_a = 1'b0;
        cons_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("hs_valid_low", int'(vld_a), 0);
        check_eq("hs_ready_high", int'(rdy_a), 1);
        check_eq("hs_yint_kept", int'(yi_a), 3);
        check_rng("hs_yfrac_kept", int'(yf_a), 16'h526A - 2, 16'h526A + 2);

        // Reset after five iterations of a data=10 run.
        @(negedge clk);
        start_a = 1'b1; data_a = 16'd10;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check_eq("mid_rst_ready", int'(rdy_a), 1);
        check_eq("mid_rst_valid", int'(vld_a), 0);
        check_eq("mid_rst_yint", int'(yi_a), 0);
        check_eq("mid_rst_yfrac", int'(yf_a), 0);
        check_eq("mid_rst_err", int'(err_a), 0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (vld_a) seen = 1;
        end
        check_eq("mid_rst_no_valid", seen, 0);

        // Start coincident with reset must not be accepted.
        start_a = 1'b1; data_a = 16'd5; rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0; start_a = 1'b0;
        check_eq("start_rst_ready", int'(rdy_a), 1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (vld_a) seen = 1;
        end
        check_eq("start_rst_no_valid", seen, 0);

        op(1'b1, 16'd10, lat, yi, yf, er);
        check_eq("b10_lat", lat, 10);
        check_eq("b10_yint", yi, 3);
        check_rng("b10_yfrac", yf, 8'h52 - 1, 8'h52 + 1);
        check_eq("b10_err", er, 0);

        for (int n = 0; n < 40; n++) begin
            x  = int'($urandom_range(65535, 1));
            op(1'b0, 16'(x), lat, yi, yf, er);
            rf = ref_frac(x, 16);
            check_eq($sformatf("rnd_a_lat x=%0d", x), lat, 18);
            check_eq($sformatf("rnd_a_yint x=%0d", x), yi, ref_int(x));
            check_rng($sformatf("rnd_a_yfrac x=%0d", x), yf, rf - 4, rf + 1);
            check_eq($sformatf("rnd_a_err x=%0d", x), er, 0);
        end

        for (int n = 0; n < 12; n++) begin
            x  = int'($urandom_range(255, 1));
            op(1'b1, 16'(x), lat, yi, yf, er);
            rf = ref_frac(x, 8);
            check_eq($sformatf("rnd_b_lat x=%0d", x), lat, 10);
            check_eq($sformatf("rnd_b_yint x=%0d", x), yi, ref_int(x));
            check_rng($sformatf("rnd_b_yfrac x=%0d", x), yf, rf - 4, rf + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
